// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings and decode helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_t;

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or
// shift-subtract step per cycle on operand magnitudes, sign fix-up at commit.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic              div_q;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  count;

    md_op_t            op_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   commit_hi;
    logic [XLEN-1:0]   commit_lo;

    always_comb begin
        op_in    = md_op_t'(op);
        neg_a_in = op_is_signed(op_in) & src_a[XLEN-1];
        neg_b_in = op_is_signed(op_in) & src_b[XLEN-1];
        mag_a_in = neg_a_in ? -src_a : src_a;
        mag_b_in = neg_b_in ? -src_b : src_b;
    end

    // acc holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        div_diff = rem_sh[XLEN-1:0] - mag_b;
        if (div_q) begin
            if (rem_sh >= {1'b0, mag_b})
                acc_next = {div_diff, acc[XLEN-2:0], 1'b1};
            else
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign flags are only ever set for signed ops, so unsigned ops pass through.
    always_comb begin
        prod      = (neg_a ^ neg_b) ? -acc_next : acc_next;
        commit_hi = prod[2*XLEN-1:XLEN];
        commit_lo = prod[XLEN-1:0];
        if (div_q) begin
            if (mag_b == '0) begin
                commit_lo = '1;
                commit_hi = neg_a ? -mag_a : mag_a;
            end else begin
                commit_lo = (neg_a ^ neg_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
                commit_hi = neg_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            div_q <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            mag_a <= '0;
            mag_b <= '0;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_q <= op_is_div(op_in);
                        neg_a <= neg_a_in;
                        neg_b <= neg_b_in;
                        mag_a <= mag_a_in;
                        mag_b <= mag_b_in;
                        acc   <= {{XLEN{1'b0}}, op_is_div(op_in) ? mag_a_in : mag_b_in};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(XLEN - 1)) begin
                        hi    <= commit_hi;
                        lo    <= commit_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// busy/done timing, start handling and asynchronous abort.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Returns at the negedge after the issue edge with start dropped.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts rising edges from now until done is seen; bounded at 40.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        #12;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mult;
        int lat, bc;
        issue(OP_MULT, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, bc);
        checks++; if (lat !== 32) begin fails++; $display("FAIL mult_latency got=%0d exp=32", lat); end
        checks++; if (bc !== 32) begin fails++; $display("FAIL mult_busy_cycles got=%0d exp=32", bc); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_busy_in_done got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
        checks++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo_hold got=%h exp=ffffffeb", lo); end
    endtask

    task automatic test_multu;
        int lat, bc;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc);
        checks++; if (bc !== 32) begin fails++; $display("FAIL multu_busy_cycles got=%0d exp=32", bc); end
        checks++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div;
        int lat, bc;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bc);
        checks++; if (lat !== 32) begin fails++; $display("FAIL div_latency got=%0d exp=32", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(lat, bc);
        checks++; if (lat !== 32) begin fails++; $display("FAIL divu0_latency got=%0d exp=32", lat); end
        checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin fails++; $display("FAIL divu0_hi got=%h exp=00000064", hi); end
        issue(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(lat, bc);
        checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'hFFFFFFF9) begin fails++; $display("FAIL div0_hi got=%h exp=fffffff9", hi); end
    endtask

    task automatic test_overflow;
        int lat, bc;
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bc);
        checks++; if (lo !== 32'h80000000) begin fails++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin fails++; $display("FAIL ovf_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_hold_start;
        int lat, bc;
        issue(OP_MULTU, 32'd5, 32'd6);
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        wait_done(lat, bc);
        checks++; if (lat !== 32) begin fails++; $display("FAIL hold_latency got=%0d exp=32", lat); end
        checks++; if (lo !== 32'd30) begin fails++; $display("FAIL hold_lo got=%h exp=0000001e", lo); end
        checks++; if (hi !== 32'd0) begin fails++; $display("FAIL hold_hi got=%h exp=00000000", hi); end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_reissue_busy got=%b exp=1", busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 32) begin fails++; $display("FAIL hold2_latency got=%0d exp=32", lat); end
        checks++; if (lo !== 32'd14) begin fails++; $display("FAIL hold2_lo got=%h exp=0000000e", lo); end
        checks++; if (hi !== 32'd2) begin fails++; $display("FAIL hold2_hi got=%h exp=00000002", hi); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(OP_MULT, 32'd3, 32'hFFFFFFFF);
        wait_done(lat, bc);
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL b2b1_lo got=%h exp=fffffffd", lo); end
        start = 1'b1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        repeat (20) @(negedge clk);
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b_hi_hold got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL b2b_lo_hold got=%h exp=fffffffd", lo); end
        wait_done(lat, bc);
        checks++; if (lat !== 12) begin fails++; $display("FAIL b2b_latency got=%0d exp=12", lat); end
        checks++; if (lo !== 32'd7) begin fails++; $display("FAIL b2b2_lo got=%h exp=00000007", lo); end
        checks++; if (hi !== 32'd1) begin fails++; $display("FAIL b2b2_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_rst_mid_run;
        int lat, bc;
        int done_seen;
        issue(OP_MULT, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin fails++; $display("FAIL abort_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin fails++; $display("FAIL abort_lo got=%h exp=0", lo); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checks++; if (done_seen !== 0) begin fails++; $display("FAIL abort_activity got=%0d exp=0", done_seen); end
        issue(OP_MULT, 32'd3, 32'd4);
        wait_done(lat, bc);
        checks++; if (lat !== 32) begin fails++; $display("FAIL rerun_latency got=%0d exp=32", lat); end
        checks++; if (lo !== 32'd12) begin fails++; $display("FAIL rerun_lo got=%h exp=0000000c", lo); end
        checks++; if (hi !== 32'd0) begin fails++; $display("FAIL rerun_hi got=%h exp=00000000", hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_overflow();
        test_hold_start();
        test_back_to_back();
        test_rst_mid_run();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
